// File: rtl/calc_controller.sv
// calc_controller: keypad calculator sequencer that gathers operands and drives an external ALU.
// Define CALC_CTRL_OVERFLOW_EN to reject digits that would overflow WIDTH bits.
module calc_controller #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             new_value,
    input  logic             new_op,
    input  logic             equal_pressed,
    input  logic [3:0]       code,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [3:0]       op_code,
    output logic             alu_start,
    output logic [WIDTH-1:0] display,
    output logic             busy,
    output logic             overflow
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        ENTRY_A,
        OP_WAIT,
        ENTRY_B,
        EXEC,
        RESULT
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] result;

    logic             do_eq;
    logic             do_op;
    logic             do_dig;
    logic             dig_room;
    logic             dig_ovf;
    logic             dig_ok;
    logic             dig_rej;
    logic [WIDTH-1:0] acc_src;
    logic [WIDTH-1:0] acc_next;

    // Strobe priority: equal beats op beats digit.
    assign do_eq  = equal_pressed;
    assign do_op  = new_op && !equal_pressed;
    assign do_dig = new_value && !new_op && !equal_pressed
                    && (code <= 4'd9);

    assign acc_src  = (state == ENTRY_B) ? operand_b : operand_a;
    assign dig_room = count < CW'(MAX_DIGITS);

`ifdef CALC_CTRL_OVERFLOW_EN
    logic [WIDTH+3:0] wide;

    assign wide     = {4'd0, acc_src} * (WIDTH+4)'(10)
                      + (WIDTH+4)'(code);
    assign acc_next = wide[WIDTH-1:0];
    assign dig_ovf  = |wide[WIDTH+3:WIDTH];
`else
    assign acc_next = acc_src * WIDTH'(10) + WIDTH'(code);
    assign dig_ovf  = 1'b0;
`endif

    assign dig_ok  = do_dig && dig_room && !dig_ovf;
    assign dig_rej = do_dig && dig_room && dig_ovf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ENTRY_A;
            operand_a <= '0;
            operand_b <= '0;
            op_code   <= '0;
            display   <= '0;
            result    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            alu_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            if (state != EXEC && (do_eq || do_op))
                overflow <= 1'b0;
            unique case (state)
                ENTRY_A: begin
                    if (do_eq) begin
                        state <= ENTRY_A;
                    end else if (do_op) begin
                        op_code <= code;
                        state   <= OP_WAIT;
                    end else if (dig_ok) begin
                        operand_a <= acc_next;
                        display   <= acc_next;
                        count     <= count + CW'(1);
                    end else if (dig_rej) begin
                        overflow <= 1'b1;
                    end
                end
                OP_WAIT: begin
                    if (do_eq) begin
                        state <= OP_WAIT;
                    end else if (do_op) begin
                        op_code <= code;
                    end else if (do_dig) begin
                        operand_b <= WIDTH'(code);
                        display   <= WIDTH'(code);
                        count     <= CW'(1);
                        state     <= ENTRY_B;
                    end
                end
                ENTRY_B: begin
                    if (do_eq) begin
                        alu_start <= 1'b1;
                        busy      <= 1'b1;
                        display   <= result;
                        state     <= EXEC;
                    end else if (do_op) begin
                        state <= ENTRY_B;
                    end else if (dig_ok) begin
                        operand_b <= acc_next;
                        display   <= acc_next;
                        count     <= count + CW'(1);
                    end else if (dig_rej) begin
                        overflow <= 1'b1;
                    end
                end
                EXEC: begin
                    if (alu_done) begin
                        operand_a <= alu_result;
                        operand_b <= '0;
                        display   <= alu_result;
                        result    <= alu_result;
                        busy      <= 1'b0;
                        state     <= RESULT;
                    end
                end
                RESULT: begin
                    // Equal repeats the last operation on the result.
                    if (do_eq) begin
                        alu_start <= 1'b1;
                        busy      <= 1'b1;
                        display   <= result;
                        state     <= EXEC;
                    end else if (do_op) begin
                        op_code <= code;
                        state   <= OP_WAIT;
                    end else if (do_dig) begin
                        operand_a <= WIDTH'(code);
                        display   <= WIDTH'(code);
                        count     <= CW'(1);
                        state     <= ENTRY_A;
                    end
                end
                default: begin
                    state <= ENTRY_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_controller.sv
// Testbench for calc_controller: directed vector table, corner sequences and
// randomized traffic checked against a behavioural calculator model.
module tb_calc_controller;

`ifdef CALC_CTRL_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        new_value;
    logic        new_op;
    logic        equal_pressed;
    logic [3:0]  code;
    logic        alu_done;
    logic [15:0] alu_result;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [3:0]  op_code;
    logic        alu_start;
    logic [15:0] display;
    logic        busy;
    logic        overflow;

    logic        b_value;
    logic        b_op;
    logic        b_eq;
    logic [3:0]  b_code;
    logic        b_done;
    logic [7:0]  b_result;
    logic [7:0]  b_a;
    logic [7:0]  b_b;
    logic [3:0]  b_opc;
    logic        b_start;
    logic [7:0]  b_disp;
    logic        b_busy;
    logic        b_ovf;

    calc_controller #(.WIDTH(16), .MAX_DIGITS(4)) dut (
        .clock(clk), .reset(reset),
        .new_value(new_value), .new_op(new_op),
        .equal_pressed(equal_pressed), .code(code),
        .alu_done(alu_done), .alu_result(alu_result),
        .operand_a(operand_a), .operand_b(operand_b),
        .op_code(op_code), .alu_start(alu_start),
        .display(display), .busy(busy), .overflow(overflow)
    );

    calc_controller #(.WIDTH(8), .MAX_DIGITS(4)) dut8 (
        .clock(clk), .reset(reset),
        .new_value(b_value), .new_op(b_op),
        .equal_pressed(b_eq), .code(b_code),
        .alu_done(b_done), .alu_result(b_result),
        .operand_a(b_a), .operand_b(b_b),
        .op_code(b_opc), .alu_start(b_start),
        .display(b_disp), .busy(b_busy), .overflow(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string n, input int unsigned act,
                       input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    // Behavioural calculator model
    localparam int S_A = 0, S_W = 1, S_B = 2, S_X = 3, S_R = 4;
    int          m_st;
    int unsigned m_a, m_b, m_op, m_disp, m_res, m_cnt;
    bit          m_ovf, m_start, m_busy;

    function automatic void m_reset();
        m_st = S_A; m_a = 0; m_b = 0; m_op = 0; m_disp = 0;
        m_res = 0; m_cnt = 0; m_ovf = 0; m_start = 0; m_busy = 0;
    endfunction

    function automatic int unsigned push_digit(input int unsigned acc,
                                               input int c);
        longint unsigned v;
        if (m_cnt >= 4) return acc;
        v = longint'(acc) * 10 + c;
        if (OVF_EN && v > 65535) begin
            m_ovf = 1;
            return acc;
        end
        m_cnt++;
        return int'(v % 65536);
    endfunction

    function automatic void m_step(input bit e, input bit o, input bit v,
                                   input int c, input bit d,
                                   input int unsigned r);
        m_start = 0;
        if (m_st == S_X) begin
            if (d) begin
                m_a = r; m_disp = r; m_res = r; m_b = 0;
                m_busy = 0; m_st = S_R;
            end
            return;
        end
        if (e || o) m_ovf = 0;
        if (e) begin
            if (m_st == S_B || m_st == S_R) begin
                m_st = S_X; m_start = 1; m_busy = 1; m_disp = m_res;
            end
        end else if (o) begin
            if (m_st != S_B) begin
                m_op = c; m_st = S_W;
            end
        end else if (v && c < 10) begin
            case (m_st)
                S_A: begin m_a = push_digit(m_a, c); m_disp = m_a; end
                S_W: begin
                    m_b = c; m_cnt = 1; m_disp = m_b; m_st = S_B;
                end
                S_B: begin m_b = push_digit(m_b, c); m_disp = m_b; end
                S_R: begin
                    m_a = c; m_cnt = 1; m_disp = m_a; m_st = S_A;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic check_model(input string n);
        chk({n, ".a"}, operand_a, m_a);
        chk({n, ".b"}, operand_b, m_b);
        chk({n, ".op"}, op_code, m_op);
        chk({n, ".start"}, alu_start, m_start);
        chk({n, ".disp"}, display, m_disp);
        chk({n, ".busy"}, busy, m_busy);
        chk({n, ".ovf"}, overflow, m_ovf);
    endtask

    task automatic tick(input bit e, input bit o, input bit v,
                        input int c, input bit d, input int unsigned r);
        equal_pressed = e; new_op = o; new_value = v;
        code = 4'(c); alu_done = d; alu_result = 16'(r);
        m_step(e, o, v, c & 15, d, r & 16'hffff);
        @(posedge clk);
        #1;
        equal_pressed = 0; new_op = 0; new_value = 0; alu_done = 0;
    endtask

    task automatic do_reset(input string n);
        reset = 1'b1;
        #1;
        m_reset();
        check_model(n);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        int e, o, v, c, d, r;
        int xa, xb, xop, xs, xd, xbusy;
    } vec_t;

    vec_t tbl[31];

    initial begin
        tbl = '{
            '{0,0,1,1,0,0,     1,0,0,0,1,0},
            '{0,0,1,2,0,0,     12,0,0,0,12,0},
            '{0,1,0,10,0,0,    12,0,10,0,12,0},
            '{0,0,1,3,0,0,     12,3,10,0,3,0},
            '{1,0,0,0,0,0,     12,3,10,1,0,1},
            '{0,0,1,7,0,0,     12,3,10,0,0,1},
            '{1,1,0,2,0,0,     12,3,10,0,0,1},
            '{0,0,0,0,1,15,    15,0,10,0,15,0},
            '{0,1,0,11,0,0,    15,0,11,0,15,0},
            '{0,0,1,5,0,0,     15,5,11,0,5,0},
            '{1,0,0,0,0,0,     15,5,11,1,15,1},
            '{0,0,0,0,0,0,     15,5,11,0,15,1},
            '{0,0,0,0,0,0,     15,5,11,0,15,1},
            '{0,0,0,0,1,10,    10,0,11,0,10,0},
            '{0,0,0,0,1,99,    10,0,11,0,10,0},
            '{0,0,1,7,0,0,     7,0,11,0,7,0},
            '{0,1,1,3,0,0,     7,0,3,0,7,0},
            '{0,0,1,9,0,0,     7,9,3,0,9,0},
            '{0,0,1,8,0,0,     7,98,3,0,98,0},
            '{0,0,1,7,0,0,     7,987,3,0,987,0},
            '{0,0,1,6,0,0,     7,9876,3,0,9876,0},
            '{0,0,1,5,0,0,     7,9876,3,0,9876,0},
            '{0,0,1,12,0,0,    7,9876,3,0,9876,0},
            '{0,1,0,5,0,0,     7,9876,3,0,9876,0},
            '{1,1,0,1,0,0,     7,9876,3,1,10,1},
            '{0,0,0,0,1,500,   500,0,3,0,500,0},
            '{1,0,0,0,0,0,     500,0,3,1,500,1},
            '{0,0,0,0,1,42,    42,0,3,0,42,0},
            '{0,0,1,4,0,0,     4,0,3,0,4,0},
            '{1,0,0,0,0,0,     4,0,3,0,4,0},
            '{0,0,1,1,0,0,     41,0,3,0,41,0}
        };
    end

    initial begin
        reset = 1'b1;
        new_value = 0; new_op = 0; equal_pressed = 0; code = 0;
        alu_done = 0; alu_result = 0;
        b_value = 0; b_op = 0; b_eq = 0; b_code = 0;
        b_done = 0; b_result = 0;
        m_reset();
        @(posedge clk);
        #1;
        chk("rst.a", operand_a, 0);
        chk("rst.disp", display, 0);
        chk("rst.busy", busy, 0);
        chk("rst.ovf", overflow, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 31; i++) begin
            string n;
            n = $sformatf("vec%0d", i);
            tick(tbl[i].e[0], tbl[i].o[0], tbl[i].v[0], tbl[i].c,
                 tbl[i].d[0], tbl[i].r);
            chk({n, ".a"}, operand_a, tbl[i].xa);
            chk({n, ".b"}, operand_b, tbl[i].xb);
            chk({n, ".op"}, op_code, tbl[i].xop);
            chk({n, ".start"}, alu_start, tbl[i].xs);
            chk({n, ".disp"}, display, tbl[i].xd);
            chk({n, ".busy"}, busy, tbl[i].xbusy);
        end

        // Keys during EXEC, then reset mid-EXEC, then a late alu_done
        tick(0, 1, 0, 10, 0, 0);
        tick(0, 0, 1, 2, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        chk("exec.start", alu_start, 1);
        tick(0, 0, 1, 5, 0, 0);
        tick(0, 1, 0, 3, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        chk("exec.a", operand_a, 41);
        chk("exec.b", operand_b, 2);
        chk("exec.op", op_code, 10);
        chk("exec.busy", busy, 1);
        do_reset("midrst");
        tick(0, 0, 0, 0, 1, 99);
        chk("late.a", operand_a, 0);
        chk("late.disp", display, 0);
        chk("late.busy", busy, 0);
        tick(0, 0, 1, 4, 0, 0);
        chk("late.entry", operand_a, 4);

        // 8-bit instance entry overflow
        for (int i = 0; i < 3; i++) begin
            b_value = 1; b_code = 9;
            tick(0, 0, 0, 0, 0, 0);
            b_value = 0;
        end
        chk("w8.a", b_a, OVF_EN ? 99 : 231);
        chk("w8.ovf", b_ovf, OVF_EN ? 1 : 0);
        b_op = 1; b_code = 10;
        tick(0, 0, 0, 0, 0, 0);
        b_op = 0;
        chk("w8.opclr", b_ovf, 0);
        chk("w8.opc", b_opc, 10);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit e, o, v, d;
            if ($urandom_range(399) == 0) begin
                do_reset("rnd.rst");
            end else begin
                e = ($urandom_range(11) == 0);
                o = ($urandom_range(7) == 0);
                v = ($urandom_range(2) == 0);
                d = (m_st == S_X) ? ($urandom_range(3) == 0)
                                  : ($urandom_range(19) == 0);
                tick(e, o, v, $urandom_range(15), d,
                     $urandom_range(65535));
                check_model("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter MAX_DIGITS, default 4, max decimal digits accepted per operand.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 new_value  input  1  one-cycle strobe; code carries a digit.
REQ-006 new_op  input  1  one-cycle strobe; code carries an operation code.
REQ-007 equal_pressed  input  1  one-cycle strobe; '=' key pressed.
REQ-008 code  input  4  digit (0-9) or operation code from the key decoder.
REQ-009 alu_done  input  1  ALU result valid strobe.
REQ-010 alu_result  input  WIDTH  ALU result, sampled when alu_done=1.
REQ-011 operand_a  output  WIDTH  first operand to ALU.
REQ-012 operand_b  output  WIDTH  second operand to ALU.
REQ-013 op_code  output  4  latched operation to ALU.
REQ-014 alu_start  output  1  one-cycle ALU launch pulse.
REQ-015 display  output  WIDTH  value currently shown.
REQ-016 busy  output  1  high while in EXEC.
REQ-017 overflow  output  1  entry-overflow flag (see Configuration).

Function
REQ-018 FSM states: ENTRY_A, OP_WAIT, ENTRY_B, EXEC, RESULT; encoding free.
REQ-019 Priority when strobes coincide: equal_pressed > new_op > new_value; lower-priority strobes in that cycle are discarded.
REQ-020 new_value with code 10-15 is ignored in every state.
REQ-021 Digit entry: acc <= acc*10 + code, truncated to WIDTH bits; digit count increments; digits beyond MAX_DIGITS ignored.
REQ-022 ENTRY_A: digit updates operand_a; new_op latches op_code -> OP_WAIT; equal ignored.
REQ-023 OP_WAIT: digit sets operand_b = code, count=1 -> ENTRY_B; new_op replaces op_code, stays; equal ignored.
REQ-024 ENTRY_B: digit updates operand_b; equal -> EXEC with alu_start=1 in the first EXEC cycle only; new_op ignored.
REQ-025 EXEC: all key strobes ignored; on alu_done, display and operand_a <= alu_result, operand_b <= 0 -> RESULT; no timeout.
REQ-026 RESULT: digit clears operand_a, loads code, count=1 -> ENTRY_A; new_op latches op_code, keeps operand_a (chaining) -> OP_WAIT; equal re-issues alu_start with same operand_b/op_code -> EXEC.
REQ-027 alu_done outside EXEC is ignored.
REQ-028 display = operand_a in ENTRY_A/OP_WAIT, operand_b in ENTRY_B, last result in EXEC/RESULT.
REQ-029 Latency: key strobe to updated register/display is exactly one clock.

Reset
REQ-030 reset asserted, any state including EXEC: immediately ENTRY_A; operand_a, operand_b, op_code, display, digit count, overflow = 0; alu_start, busy = 0.
REQ-031 alu_done arriving after reset aborted EXEC is ignored.

Configuration
REQ-032 Macro CALC_CTRL_OVERFLOW_EN defined: a digit whose acc*10+code exceeds 2^WIDTH-1 is rejected (acc unchanged), overflow set; overflow clears on next new_op, equal or reset.
REQ-033 Macro undefined: wrap-around truncation per REQ-021; overflow tied to 0.

Verification
REQ-034 Keys 1,2,+(code 10),3,=; alu_done with result 15 three cycles after alu_start -> operand_a=12, operand_b=3, op_code=10, one alu_start pulse, display=15, state RESULT.
REQ-035 From RESULT(15): op 11, digit 5, = -> operand_a=15 retained, operand_b=5, alu_start pulses once.
REQ-036 new_op and new_value same cycle in ENTRY_A -> op latched, digit discarded, state OP_WAIT.
REQ-037 Keys pressed during EXEC, then reset mid-EXEC, then late alu_done -> keys ignored; all outputs 0, state ENTRY_A; late alu_done no effect.
REQ-038 WIDTH=8, MAX_DIGITS=4, enter 9,9,9 -> with macro: operand_a=99, overflow=1; without: operand_a=999 mod 256=231, overflow=0.
